axi_sram_slave: RTL

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_pkg.sv | 69 ++++++
 rtl/axi_sram_slave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types for the AXI-to-SRAM slave: FSM states, AXI response codes
// and the default 32-bit AXI request/response channel structs.
package axi_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEM,
    WR_DRAIN,
    WR_RESP,
    RD_MEM,
    RD_DATA
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only 4-byte transfers reach the SRAM.
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam int unsigned ID_W = 4;

  typedef struct packed {
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic [7:0]      len;
    logic [2:0]      size;
  } axi_32_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_32_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_32_b_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
  } axi_32_r_t;

  typedef struct packed {
    axi_32_ax_t aw;
    logic       aw_valid;
    axi_32_w_t  w;
    logic       w_valid;
    logic       b_ready;
    axi_32_ax_t ar;
    logic       ar_valid;
    logic       r_ready;
  } axi_32_req_t;

  typedef struct packed {
    logic      aw_ready;
    logic      w_ready;
    logic      b_valid;
    axi_32_b_t b;
    logic      ar_ready;
    logic      r_valid;
    axi_32_r_t r;
  } axi_32_resp_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI slave in front of a single-port SRAM. One transaction at a time;
// only single-beat 32-bit accesses touch the SRAM, everything else is
// answered with an error response (DECERR out of range, SLVERR bad burst/size).
//
// Handshake rule on every channel: a transfer happens in the cycle where
// both valid and ready are high; valid, once raised by this block (B, R),
// stays high with stable payload until the matching ready is seen.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter type                   axi_req_t  = axi_32_req_t,
  parameter type                   axi_resp_t = axi_32_resp_t,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  axi_req_t                     axi_req_i,
  output axi_resp_t                    axi_resp_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]      mem_be_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * MEM_WORDS);

  // A borrow out of the subtraction means the address lies below the base.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[ADDR_WIDTH] && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  state_e                  state_q;
  logic                    mem_req_q, mem_we_q;
  logic [IDX_W-1:0]        mem_addr_q;
  logic [DATA_WIDTH/8-1:0] mem_be_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    b_valid_q;
  logic [ID_W-1:0]         b_id_q;
  logic [1:0]              b_resp_q;
  logic                    r_valid_q;
  logic [ID_W-1:0]         r_id_q;
  logic [1:0]              r_resp_q;
  logic [7:0]              beats_q;     // R beats still to send after the current one
  logic                    rd_first_q;  // first R cycle: data comes straight from the SRAM
  logic                    rd_err_q;
  logic [DATA_WIDTH-1:0]   r_hold_q;

  logic wr_pair, aw_ok, ar_ok, aw_hit, ar_hit;
  logic [DATA_WIDTH-1:0] r_data;
  axi_resp_t resp;

  assign wr_pair = axi_req_i.aw_valid && axi_req_i.w_valid;
  assign aw_hit  = in_range(axi_req_i.aw.addr);
  assign ar_hit  = in_range(axi_req_i.ar.addr);
  assign aw_ok   = aw_hit && (axi_req_i.aw.len == 8'd0) && (axi_req_i.aw.size == SIZE_WORD);
  assign ar_ok   = ar_hit && (axi_req_i.ar.len == 8'd0) && (axi_req_i.ar.size == SIZE_WORD);

  // R data: live SRAM output on the first R cycle, held copy afterwards.
  assign r_data = rd_first_q ? (rd_err_q ? '0 : mem_rdata_i) : r_hold_q;

  // Readys are decoded from state and the live valids; writes win over reads.
  always_comb begin
    resp            = '0;
    resp.aw_ready   = rst_ni && (state_q == IDLE) && wr_pair;
    resp.w_ready    = rst_ni && (((state_q == IDLE) && wr_pair) || (state_q == WR_DRAIN));
    resp.ar_ready   = rst_ni && (state_q == IDLE) && !wr_pair && axi_req_i.ar_valid;
    resp.b_valid    = b_valid_q;
    resp.b.id       = b_id_q;
    resp.b.resp     = b_resp_q;
    resp.r_valid    = r_valid_q;
    resp.r.id       = r_id_q;
    resp.r.data     = r_data;
    resp.r.resp     = r_resp_q;
    resp.r.last     = r_valid_q && (beats_q == 8'd0);
  end

  assign axi_resp_o  = resp;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

  // Transaction FSM with all channel and SRAM outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      b_valid_q   <= 1'b0;
      b_id_q      <= '0;
      b_resp_q    <= RESP_OKAY;
      r_valid_q   <= 1'b0;
      r_id_q      <= '0;
      r_resp_q    <= RESP_OKAY;
      beats_q     <= '0;
      rd_first_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      r_hold_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_pair) begin
            b_id_q      <= axi_req_i.aw.id;
            mem_addr_q  <= word_idx(axi_req_i.aw.addr);
            mem_be_q    <= axi_req_i.w.strb;
            mem_wdata_q <= axi_req_i.w.data;
            if (!aw_hit)     b_resp_q <= RESP_DECERR;
            else if (!aw_ok) b_resp_q <= RESP_SLVERR;
            else             b_resp_q <= RESP_OKAY;
            mem_req_q <= aw_ok;
            mem_we_q  <= aw_ok;
            // A rejected burst still has to have its remaining W beats swallowed.
            state_q   <= (aw_ok || axi_req_i.w.last) ? WR_MEM : WR_DRAIN;
          end else if (axi_req_i.ar_valid) begin
            r_id_q     <= axi_req_i.ar.id;
            beats_q    <= axi_req_i.ar.len;
            mem_addr_q <= word_idx(axi_req_i.ar.addr);
            r_hold_q   <= '0;
            rd_err_q   <= !ar_ok;
            if (!ar_hit)     r_resp_q <= RESP_DECERR;
            else if (!ar_ok) r_resp_q <= RESP_SLVERR;
            else             r_resp_q <= RESP_OKAY;
            mem_req_q  <= ar_ok;
            mem_we_q   <= 1'b0;
            state_q    <= RD_MEM;
          end
        end
        WR_MEM: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          b_valid_q <= 1'b1;
          state_q   <= WR_RESP;
        end
        WR_DRAIN: begin
          if (axi_req_i.w_valid && axi_req_i.w.last) begin
            b_valid_q <= 1'b1;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_req_i.b_ready) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RD_MEM: begin
          mem_req_q  <= 1'b0;
          r_valid_q  <= 1'b1;
          rd_first_q <= 1'b1;
          state_q    <= RD_DATA;
        end
        RD_DATA: begin
          rd_first_q <= 1'b0;
          if (rd_first_q && !rd_err_q) r_hold_q <= mem_rdata_i;
          if (axi_req_i.r_ready) begin
            if (beats_q == 8'd0) begin
              r_valid_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              beats_q <= beats_q - 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
